// File: rtl/sdram_arb_pkg.sv
// Shared types and width helpers for the SDRAM host-port arbiter.
package sdram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } arb_state_e;

    // Channel index width; a 2-channel arbiter still needs one bit.
    function automatic int ch_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    // Timeout counter width; kept at one bit when the timeout is disabled.
    function automatic int cnt_width(input int t);
        return (t > 0) ? $clog2(t + 1) : 1;
    endfunction

endpackage

// File: rtl/sdram_arb_pick.sv
// Combinational request picker: rotating priority after the pointer, or fixed
// priority with the lowest index winning.
module sdram_arb_pick
    import sdram_arb_pkg::*;
#(
    parameter int N_CH      = 4,
    parameter int FIXED_PRI = 0,
    localparam int CH_W     = ch_width(N_CH)
) (
    input  logic [N_CH-1:0] req_i,
    input  logic [CH_W-1:0] ptr_i,
    output logic [CH_W-1:0] win_o,
    output logic            vld_o
);

    always_comb begin
        int idx;
        idx   = 0;
        win_o = '0;
        vld_o = 1'b0;
        if (FIXED_PRI != 0) begin
            for (int i = N_CH - 1; i >= 0; i--) begin
                if (req_i[i]) begin
                    win_o = CH_W'(i);
                    vld_o = 1'b1;
                end
            end
        end else begin
            // Walk from farthest to nearest so the channel just after the pointer wins.
            for (int k = N_CH; k >= 1; k--) begin
                idx = (int'(ptr_i) + k) % N_CH;
                if (req_i[idx]) begin
                    win_o = CH_W'(idx);
                    vld_o = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/sdram_host_arb.sv
// N-channel arbiter serialising rd/wr requests onto the single sdram_cntl
// host port, with operand latching at grant and per-operation timeout.
module sdram_host_arb
    import sdram_arb_pkg::*;
#(
    parameter int N_CH      = 4,
    parameter int ADDR_W    = 24,
    parameter int DATA_W    = 16,
    parameter int FIXED_PRI = 0,
    parameter int TIMEOUT   = 1023,
    localparam int CH_W     = ch_width(N_CH)
) (
    input  logic                   clk,
    input  logic                   rst_i,
    input  logic [N_CH-1:0]        ch_rd_i,
    input  logic [N_CH-1:0]        ch_wr_i,
    input  logic [N_CH*ADDR_W-1:0] ch_addr_i,
    input  logic [N_CH*DATA_W-1:0] ch_data_i,
    output logic [DATA_W-1:0]      ch_data_o,
    output logic [N_CH-1:0]        ch_done_o,
    output logic [N_CH-1:0]        ch_err_o,
    output logic                   host_rd_o,
    output logic                   host_wr_o,
    output logic [ADDR_W-1:0]      host_addr_o,
    output logic [DATA_W-1:0]      host_data_o,
    input  logic [DATA_W-1:0]      host_data_i,
    input  logic                   host_done_i,
    output logic [CH_W-1:0]        grant_o,
    output logic                   busy_o
);

    localparam int CNT_W   = cnt_width(TIMEOUT);
    localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    arb_state_e        state_q, state_d;
    logic [CH_W-1:0]   ptr_q, ptr_d;
    logic [CH_W-1:0]   id_q, id_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [N_CH-1:0]   done_q, done_d;
    logic [N_CH-1:0]   err_q, err_d;
    logic              busy_q, busy_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [N_CH-1:0]   req;
    logic [CH_W-1:0]   pick_win;
    logic              pick_vld;
    logic              to_hit;

    assign req = ch_rd_i | ch_wr_i;

    sdram_arb_pick #(
        .N_CH      (N_CH),
        .FIXED_PRI (FIXED_PRI)
    ) u_pick (
        .req_i (req),
        .ptr_i (ptr_q),
        .win_o (pick_win),
        .vld_o (pick_vld)
    );

    // With TIMEOUT=0 the compare is constant false and the counter is pruned.
    assign to_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TO_LAST));

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        done_d  = '0;
        err_d   = '0;
        cnt_d   = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    state_d = BUSY;
                    id_d    = pick_win;
                    ptr_d   = pick_win;
                    wr_d    = ch_wr_i[pick_win];
                    rd_d    = ~ch_wr_i[pick_win];
                    addr_d  = ch_addr_i[int'(pick_win)*ADDR_W +: ADDR_W];
                    wdata_d = ch_data_i[int'(pick_win)*DATA_W +: DATA_W];
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                // A done arriving on the timeout cycle still counts as success.
                if (host_done_i) begin
                    state_d      = RELEASE;
                    rd_d         = 1'b0;
                    wr_d         = 1'b0;
                    done_d[id_q] = 1'b1;
                    rdata_d      = wr_q ? '0 : host_data_i;
                end else if (to_hit) begin
                    state_d     = RELEASE;
                    rd_d        = 1'b0;
                    wr_d        = 1'b0;
                    err_d[id_q] = 1'b1;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_q <= IDLE;
            ptr_q   <= CH_W'(N_CH - 1);
            id_q    <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            done_q  <= '0;
            err_q   <= '0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ch_data_o   = rdata_q;
    assign ch_done_o   = done_q;
    assign ch_err_o    = err_q;
    assign host_rd_o   = rd_q;
    assign host_wr_o   = wr_q;
    assign host_addr_o = addr_q;
    assign host_data_o = wdata_q;
    assign grant_o     = id_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_sdram_host_arb.sv
// Directed bench for sdram_host_arb: round-robin instance with TIMEOUT=8 and
// a fixed-priority instance sharing the clock and reset.
module tb_sdram_host_arb;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Round-robin DUT
    logic [3:0]  a_rd, a_wr;
    logic [95:0] a_addr;
    logic [63:0] a_wdata;
    logic [15:0] a_dout, a_hdata_in, a_haddr_unused_d;
    logic [3:0]  a_done, a_err;
    logic        a_hrd, a_hwr, a_hdone, a_busy;
    logic [23:0] a_haddr;
    logic [15:0] a_hdata_out;
    logic [1:0]  a_grant;

    // Fixed-priority DUT
    logic [3:0]  b_rd, b_wr;
    logic [15:0] b_dout, b_hdata_in, b_hdata_out;
    logic [3:0]  b_done, b_err;
    logic        b_hrd, b_hwr, b_hdone, b_busy;
    logic [23:0] b_haddr;
    logic [1:0]  b_grant;

    logic [23:0] ch_addr [4];
    logic [15:0] ch_wdat [4];

    int total  = 0;
    int passed = 0;

    sdram_host_arb #(.N_CH(4), .ADDR_W(24), .DATA_W(16), .FIXED_PRI(0), .TIMEOUT(8)) u_rr (
        .clk(clk), .rst_i(rst), .ch_rd_i(a_rd), .ch_wr_i(a_wr),
        .ch_addr_i(a_addr), .ch_data_i(a_wdata), .ch_data_o(a_dout),
        .ch_done_o(a_done), .ch_err_o(a_err), .host_rd_o(a_hrd), .host_wr_o(a_hwr),
        .host_addr_o(a_haddr), .host_data_o(a_hdata_out), .host_data_i(a_hdata_in),
        .host_done_i(a_hdone), .grant_o(a_grant), .busy_o(a_busy)
    );

    sdram_host_arb #(.N_CH(4), .ADDR_W(24), .DATA_W(16), .FIXED_PRI(1), .TIMEOUT(8)) u_fp (
        .clk(clk), .rst_i(rst), .ch_rd_i(b_rd), .ch_wr_i(b_wr),
        .ch_addr_i(a_addr), .ch_data_i(a_wdata), .ch_data_o(b_dout),
        .ch_done_o(b_done), .ch_err_o(b_err), .host_rd_o(b_hrd), .host_wr_o(b_hwr),
        .host_addr_o(b_haddr), .host_data_o(b_hdata_out), .host_data_i(b_hdata_in),
        .host_done_i(b_hdone), .grant_o(b_grant), .busy_o(b_busy)
    );

    typedef struct {
        logic [3:0]  add_rd;
        logic [3:0]  add_wr;
        int          ch;
        logic        wr;
        int          dly;
        logic [15:0] hdata;
        logic [15:0] exp_dout;
    } vec_t;

    vec_t tbl [10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Wait for the grant, hold done off for dly cycles, then complete the op.
    task automatic serve(input int ch, input logic wr, input int dly,
                         input logic [15:0] hdata, input logic [15:0] exp_dout, input int exp_n);
        int n;
        n = 0;
        while (!(a_hrd || a_hwr) && n < 20) begin
            tick();
            n++;
        end
        check("grant_latency", n, exp_n);
        check("grant_id", {30'd0, a_grant}, ch);
        check("host_wr", {31'd0, a_hwr}, {31'd0, wr});
        check("host_rd", {31'd0, a_hrd}, {31'd0, ~wr});
        check("host_addr", {8'd0, a_haddr}, {8'd0, ch_addr[ch]});
        if (wr) check("host_wdata", {16'd0, a_hdata_out}, {16'd0, ch_wdat[ch]});
        for (int i = 0; i < dly; i++) begin
            tick();
            check("op_hold", {a_hrd | a_hwr, a_err}, {1'b1, 4'b0000});
        end
        a_hdone    = 1'b1;
        a_hdata_in = hdata;
        tick();
        a_hdone    = 1'b0;
        a_hdata_in = 16'hDEAD;
        check("done_pulse", {28'd0, a_done}, 32'd1 << ch);
        check("done_no_err", {28'd0, a_err}, 32'd0);
        check("done_rdata", {16'd0, a_dout}, {16'd0, exp_dout});
        check("done_host_low", {a_hrd, a_hwr, a_busy}, 3'b001);
        a_rd[ch] = 1'b0;
        a_wr[ch] = 1'b0;
        tick();
        check("done_single", {28'd0, a_done}, 32'd0);
        check("release_gap", {a_hrd, a_hwr}, 2'b00);
    endtask

    initial begin
        int n;
        a_rd = '0; a_wr = '0; a_hdone = 1'b0; a_hdata_in = '0; a_haddr_unused_d = '0;
        b_rd = '0; b_wr = '0; b_hdone = 1'b0; b_hdata_in = '0;
        ch_addr = '{24'h000100, 24'h000777, 24'h001234, 24'h00ABCD};
        ch_wdat = '{16'hA000, 16'hA111, 16'hA222, 16'hA333};
        for (int i = 0; i < 4; i++) begin
            a_addr[i*24 +: 24]  = ch_addr[i];
            a_wdata[i*16 +: 16] = ch_wdat[i];
        end

        //          add_rd   add_wr   ch wr dly hdata     exp_dout
        tbl[0] = '{4'b0000, 4'b1111, 0, 1'b1, 3, 16'h5555, 16'h0000};
        tbl[1] = '{4'b0000, 4'b0000, 1, 1'b1, 3, 16'h5555, 16'h0000};
        tbl[2] = '{4'b0000, 4'b0000, 2, 1'b1, 3, 16'h5555, 16'h0000};
        tbl[3] = '{4'b0000, 4'b0000, 3, 1'b1, 3, 16'h5555, 16'h0000};
        tbl[4] = '{4'b0100, 4'b0000, 2, 1'b0, 2, 16'hBEEF, 16'hBEEF};
        tbl[5] = '{4'b1001, 4'b0000, 3, 1'b0, 1, 16'h1357, 16'h1357};
        tbl[6] = '{4'b0000, 4'b0000, 0, 1'b0, 0, 16'h2468, 16'h2468};
        tbl[7] = '{4'b0010, 4'b0010, 1, 1'b1, 4, 16'hFFFF, 16'h0000};
        tbl[8] = '{4'b0101, 4'b0000, 2, 1'b0, 2, 16'h0A0A, 16'h0A0A};
        tbl[9] = '{4'b0000, 4'b0000, 0, 1'b0, 5, 16'h00F0, 16'h00F0};

        // Reset state
        tick();
        tick();
        check("rst_host", {a_hrd, a_hwr, a_busy}, 3'b000);
        check("rst_pulses", {24'd0, a_done, a_err}, 32'd0);
        check("rst_grant", {30'd0, a_grant}, 32'd0);
        check("rst_addr", {8'd0, a_haddr}, 32'd0);
        check("rst_dout", {16'd0, a_dout}, 32'd0);
        rst = 1'b0;

        // Round-robin service order, reads and writes
        for (int v = 0; v < 10; v++) begin
            a_rd = a_rd | tbl[v].add_rd;
            a_wr = a_wr | tbl[v].add_wr;
            serve(tbl[v].ch, tbl[v].wr, tbl[v].dly, tbl[v].hdata, tbl[v].exp_dout, 1);
        end

        // Spurious done while idle
        a_hdone = 1'b1;
        tick();
        a_hdone = 1'b0;
        check("spurious_done", {a_done, a_err, a_busy}, 9'd0);

        // Timeout: ch1 read never completes, ch3 write waits behind it
        a_rd = 4'b0010;
        a_wr = 4'b1000;
        n = 0;
        while (!(a_hrd || a_hwr) && n < 20) begin
            tick();
            n++;
        end
        check("to_grant", {29'd0, a_grant, a_hrd}, {29'd0, 2'd1, 1'b1});
        for (int k = 1; k <= 7; k++) begin
            tick();
            check("to_wait", {a_hrd, a_err}, {1'b1, 4'b0000});
        end
        tick();
        check("to_err", {a_err, a_done, a_hrd}, {4'b0010, 4'b0000, 1'b0});
        a_rd = 4'b0000;
        tick();
        check("to_err_single", {28'd0, a_err}, 32'd0);
        serve(3, 1'b1, 2, 16'h0000, 16'h0000, 1);

        // Done on the exact timeout cycle
        a_rd = 4'b0001;
        serve(0, 1'b0, 7, 16'h7777, 16'h7777, 1);

        // Reset while busy
        a_rd = 4'b0010;
        n = 0;
        while (!(a_hrd || a_hwr) && n < 20) begin
            tick();
            n++;
        end
        check("rst_op_grant", {29'd0, a_grant, a_hrd}, {29'd0, 2'd1, 1'b1});
        tick();
        tick();
        a_rd = 4'b0111;
        rst  = 1'b1;
        tick();
        rst  = 1'b0;
        check("rst_abort_host", {a_hrd, a_hwr, a_busy}, 3'b000);
        check("rst_abort_pulses", {24'd0, a_done, a_err}, 32'd0);
        serve(0, 1'b0, 1, 16'h0C0C, 16'h0C0C, 1);
        serve(1, 1'b0, 1, 16'h0D0D, 16'h0D0D, 1);
        serve(2, 1'b0, 1, 16'h0E0E, 16'h0E0E, 1);

        // Fixed priority: ch1 keeps winning over ch3 until it drops
        b_rd = 4'b0010;
        b_wr = 4'b1000;
        for (int r = 0; r < 3; r++) begin
            n = 0;
            while (!(b_hrd || b_hwr) && n < 20) begin
                tick();
                n++;
            end
            check("fp_ch1_grant", {29'd0, b_grant, b_hrd}, {29'd0, 2'd1, 1'b1});
            tick();
            b_hdone = 1'b1;
            tick();
            b_hdone = 1'b0;
            check("fp_ch1_done", {28'd0, b_done}, 32'h2);
            if (r == 2) b_rd = 4'b0000;
            tick();
        end
        n = 0;
        while (!(b_hrd || b_hwr) && n < 20) begin
            tick();
            n++;
        end
        check("fp_ch3_grant", {29'd0, b_grant, b_hwr}, {29'd0, 2'd3, 1'b1});
        b_hdone = 1'b1;
        tick();
        b_hdone = 1'b0;
        check("fp_ch3_done", {28'd0, b_done}, 32'h8);
        b_wr = 4'b0000;
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
